// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: FSM state encodings and RegisterFile timing constants for regfile_port_arbiter
package regfile_arb_pkg;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_READ      = 2'd2;
    localparam logic [1:0] ST_READ_WAIT = 2'd3;
    localparam int RF_RD_LATENCY = 1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant from a request vector; round-robin when REGFILE_ARB_RR_EN is defined, else lowest index wins
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
`ifdef REGFILE_ARB_RR_EN
    input  logic               CLK,
    input  logic               RST,
`endif
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);
`ifdef REGFILE_ARB_RR_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    // search starts one past the last grant; the pointer moves only when a grant is issued
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (en_i && !found && req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                gnt_o[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
                ptr_d = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end
    // pointer resets to the last requester so requester 0 wins first
    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= PW'(NUM_REQ - 1);
        else     ptr_q <= ptr_d;
    end
`else
    // isolate the lowest set request bit
    always_comb gnt_o = en_i ? (req_i & (~req_i + 1'b1)) : '0;
`endif
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one single-port RegisterFile among NUM_REQ requesters (round-robin under REGFILE_ARB_RR_EN)
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int MEM_DEPTH  = 8,
    parameter int MEM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [MEM_WIDTH-1:0]          rsp_rdata,
    output logic                          busy,
    output logic [MEM_WIDTH-1:0]          rf_wr_data,
    output logic [ADDR_WIDTH-1:0]         rf_address,
    output logic                          rf_wr_en,
    output logic                          rf_rd_en,
    input  logic [MEM_WIDTH-1:0]          rf_rd_data
);
    logic [1:0]            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt, owner_q, owner_d, rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
    logic [MEM_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d, sel_wdata;
    logic                  sel_wr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef REGFILE_ARB_RR_EN
        .CLK  (CLK),
        .RST  (RST),
`endif
        .req_i(req_valid),
        .en_i (state_q == ST_IDLE),
        .gnt_o(gnt)
    );

    // route the winning requester's command fields
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
                sel_wr    = req_wr[i];
            end
        end
    end

    // next state: accept in IDLE, one cycle per access phase, capture read data on leaving READ_WAIT
    always_comb begin
        state_d     = (state_q == ST_IDLE) ? (|gnt ? (sel_wr ? ST_WRITE : ST_READ) : ST_IDLE) :
                      (state_q == ST_READ) ? ST_READ_WAIT : ST_IDLE;
        addr_d      = |gnt ? sel_addr : addr_q;
        wdata_d     = |gnt ? sel_wdata : wdata_q;
        owner_d     = |gnt ? gnt : owner_q;
        rdata_d     = (state_q == ST_READ_WAIT) ? rf_rd_data : rdata_q;
        rsp_valid_d = (state_q == ST_READ_WAIT) ? owner_q : '0;
    end

    // state registers; reset abandons any in-flight command
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign rf_wr_data = wdata_q;
    assign rf_address = addr_q;
    assign rf_wr_en   = (state_q == ST_WRITE);
    assign rf_rd_en   = (state_q == ST_READ);
endmodule
